// File: rtl/activity_counter_pkg.sv
// activity_counter_pkg: shared FSM encoding and sizing helpers
// for the activity_counter block.
package activity_counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAPT = 2'd1,
    HOLD = 2'd2
  } snap_state_e;

  function automatic logic [31:0] cnt_max(input int w);
    return 32'hFFFF_FFFF >> (32 - w);
  endfunction

  function automatic int sel_w(input int ch);
    return (ch <= 1) ? 1 : $clog2(ch);
  endfunction

endpackage

// File: rtl/act_chan_counter.sv
// act_chan_counter: one channel of edge detect plus saturating count.
// ACT_BOTH_EDGES_EN selects toggle counting instead of rising edges.
module act_chan_counter
  import activity_counter_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             act_i,
  input  logic             enable_i,
  input  logic             clear_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             sat_o
);

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(cnt_max(CNT_W));

  logic             prev_q;
  logic             evt;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             sat_q;
  logic             sat_d;

`ifdef ACT_BOTH_EDGES_EN
  assign evt = act_i ^ prev_q;
`else
  assign evt = act_i & ~prev_q;
`endif

  // clear wins over a coincident event
  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (clear_i) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (enable_i && evt &&
                 cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
      sat_d = sat_q | (cnt_d == CNT_MAX);
    end
  end

  // prev resets high so a net already high is not counted
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      prev_q <= 1'b1;
      cnt_q  <= '0;
      sat_q  <= 1'b0;
    end else begin
      prev_q <= act_i;
      cnt_q  <= cnt_d;
      sat_q  <= sat_d;
    end
  end

  assign cnt_o = cnt_q;
  assign sat_o = sat_q;

endmodule

// File: rtl/activity_counter.sv
// activity_counter: per-net switching activity counters with a
// snapshot/ack readout. Define ACT_BOTH_EDGES_EN to count both edges.
module activity_counter
  import activity_counter_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 16,
  parameter int SEL_W    = 2
) (
  input  logic                clk,
  input  logic                reset_L,
  input  logic [CHANNELS-1:0] act_in,
  input  logic                enable,
  input  logic                clear_req,
  input  logic                snap_req,
  input  logic                snap_ack,
  input  logic [SEL_W-1:0]    rd_sel,
  output logic [CNT_W-1:0]    rd_data,
  output logic                rd_valid,
  output logic                busy,
  output logic [CHANNELS-1:0] sat_flags
);

  logic [CHANNELS-1:0][CNT_W-1:0] cnt;
  logic [CHANNELS-1:0][CNT_W-1:0] shadow_q;
  snap_state_e                    state_q;
  logic                           busy_q;
  logic                           valid_q;
  logic [CNT_W-1:0]               rd_data_d;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    act_chan_counter #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk      (clk),
      .reset_L  (reset_L),
      .act_i    (act_in[g]),
      .enable_i (enable),
      .clear_i  (clear_req),
      .cnt_o    (cnt[g]),
      .sat_o    (sat_flags[g])
    );
  end

  // shadow takes the registered (pre-increment, pre-clear) counts
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      shadow_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (snap_req) begin
            state_q  <= CAPT;
            busy_q   <= 1'b1;
            shadow_q <= cnt;
          end
        end
        CAPT: begin
          state_q <= HOLD;
          busy_q  <= 1'b0;
          valid_q <= 1'b1;
        end
        HOLD: begin
          if (snap_ack) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  // out-of-range selects match no channel and read zero
  always_comb begin
    rd_data_d = '0;
    if (valid_q) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (rd_sel == SEL_W'(i)) rd_data_d = shadow_q[i];
      end
    end
  end

  assign rd_data  = rd_data_d;
  assign rd_valid = valid_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_activity_counter.sv
// tb_activity_counter: randomized + directed scoreboard bench
// against an integer reference model of activity_counter.
module tb_activity_counter;

  localparam int CH   = 4;
  localparam int W    = 4;
  localparam int SW   = 2;
  localparam int MAXV = (1 << W) - 1;

  typedef logic [CH-1:0][W-1:0] snap_t;

  logic          clk = 1'b0;
  logic          reset_L = 1'b0;
  logic [CH-1:0] act_in = '0;
  logic          enable = 1'b0;
  logic          clear_req = 1'b0;
  logic          snap_req = 1'b0;
  logic          snap_ack = 1'b0;
  logic [SW-1:0] rd_sel = '0;
  logic [W-1:0]  rd_data;
  logic          rd_valid;
  logic          busy;
  logic [CH-1:0] sat_flags;

  int tests = 0;
  int fails = 0;

  int    m_cnt  [CH];
  bit    m_sat  [CH];
  bit    m_prev [CH];
  int    m_state;
  snap_t exp_q [$];

  always #5 clk = ~clk;

  activity_counter #(
    .CHANNELS(CH),
    .CNT_W   (W),
    .SEL_W   (SW)
  ) dut (
    .clk      (clk),
    .reset_L  (reset_L),
    .act_in   (act_in),
    .enable   (enable),
    .clear_req(clear_req),
    .snap_req (snap_req),
    .snap_ack (snap_ack),
    .rd_sel   (rd_sel),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .busy     (busy),
    .sat_flags(sat_flags)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < CH; i++) begin
      m_cnt[i]  = 0;
      m_sat[i]  = 1'b0;
      m_prev[i] = 1'b1;
    end
    m_state = 0;
    exp_q.delete();
  endfunction

  // state: 0 idle, 1 capturing, 2 holding a snapshot
  function automatic void model_step();
    snap_t s;
    bit    ev;
    if (!reset_L) return;
    if (m_state == 0) begin
      if (snap_req) begin
        for (int i = 0; i < CH; i++) s[i] = W'(m_cnt[i]);
        exp_q.push_back(s);
        m_state = 1;
      end
    end else if (m_state == 1) begin
      m_state = 2;
    end else if (snap_ack) begin
      m_state = 0;
    end
    for (int i = 0; i < CH; i++) begin
`ifdef ACT_BOTH_EDGES_EN
      ev = (act_in[i] != m_prev[i]);
`else
      ev = act_in[i] && !m_prev[i];
`endif
      if (clear_req) begin
        m_cnt[i] = 0;
        m_sat[i] = 1'b0;
      end else if (enable && ev && m_cnt[i] < MAXV) begin
        m_cnt[i]++;
        if (m_cnt[i] == MAXV) m_sat[i] = 1'b1;
      end
      m_prev[i] = act_in[i];
    end
  endfunction

  task automatic cyc(input logic [CH-1:0] a,
                     input logic en, input logic clr,
                     input logic snp, input logic ack,
                     input logic [SW-1:0] sel);
    act_in    = a;
    enable    = en;
    clear_req = clr;
    snap_req  = snp;
    snap_ack  = ack;
    rd_sel    = sel;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++)
      cyc('0, 1'b1, 1'b0, 1'b0, 1'b0, SW'($urandom));
  endtask

  task automatic pulse(input int ch, input logic en);
    logic [CH-1:0] a;
    a = '0;
    a[ch] = 1'b1;
    cyc(a, en, 1'b0, 1'b0, 1'b0, SW'($urandom));
    cyc('0, en, 1'b0, 1'b0, 1'b0, SW'($urandom));
  endtask

  task automatic read_all();
    cyc('0, 1'b1, 1'b0, 1'b1, 1'b0, '0);
    idle(1);
    for (int s = 0; s < CH; s++)
      cyc('0, 1'b1, 1'b0, 1'b0, 1'b0, SW'(s));
    cyc('0, 1'b1, 1'b0, 1'b0, 1'b1, '0);
    idle(1);
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    #1;
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sat", sat_flags, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    reset_L = 1'b1;
  endtask

  initial begin : monitor
    snap_t         cur;
    bit            have;
    logic          pv;
    logic [CH-1:0] es;
    have = 1'b0;
    pv   = 1'b0;
    cur  = '0;
    forever begin
      @(negedge clk);
      if (!reset_L) begin
        have = 1'b0;
        pv   = 1'b0;
        continue;
      end
      for (int i = 0; i < CH; i++) es[i] = m_sat[i];
      chk("busy", busy, 32'(m_state == 1));
      chk("rd_valid", rd_valid, 32'(m_state == 2));
      chk("sat_flags", sat_flags, es);
      if (rd_valid && !pv) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL snap_pop: got rd_valid, expected no snapshot");
        end else begin
          cur  = exp_q.pop_front();
          have = 1'b1;
        end
      end
      if (rd_valid && have)
        chk("rd_data", rd_data, cur[rd_sel]);
      else if (!rd_valid)
        chk("rd_data_idle", rd_data, 0);
      pv = rd_valid;
    end
  end

  initial begin
    do_reset();

    // three pulses on ch0, then read every channel
    for (int k = 0; k < 3; k++) pulse(0, 1'b1);
    read_all();

    // saturation on ch2 and clear
    do_reset();
    for (int k = 0; k < 20; k++) pulse(2, 1'b1);
    @(negedge clk);
    chk("sat_ch2", sat_flags, 4'b0100);
    read_all();
    cyc('0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    @(negedge clk);
    chk("sat_cleared", sat_flags, 0);
    read_all();

    // snapshot-and-clear in one cycle, with an event dropped
    for (int k = 0; k < 5; k++) pulse(1, 1'b1);
    cyc(4'b0001, 1'b1, 1'b1, 1'b1, 1'b0, '0);
    cyc('0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
    for (int k = 0; k < 3; k++)
      cyc('0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
    cyc('0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1);
    read_all();

    // disabled counting, ignored snap_req in HOLD
    for (int k = 0; k < 4; k++) pulse(3, 1'b0);
    cyc('0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd3);
    idle(1);
    cyc('0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd3);
    for (int k = 0; k < 4; k++)
      cyc('0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3);
    cyc('0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3);
    idle(2);

    // reset in HOLD, inputs high through release
    pulse(0, 1'b1);
    cyc('1, 1'b1, 1'b0, 1'b1, 1'b0, '0);
    cyc('1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    cyc('1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    do_reset();
    for (int k = 0; k < 3; k++)
      cyc('1, 1'b1, 1'b0, 1'b0, 1'b0, SW'($urandom));
    read_all();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        cyc(CH'($urandom),
            $urandom_range(0, 9) != 0,
            $urandom_range(0, 29) == 0,
            $urandom_range(0, 5) == 0,
            $urandom_range(0, 3) == 0,
            SW'($urandom));
      end
    end
    for (int k = 0; k < 4; k++)
      cyc('0, 1'b1, 1'b0, 1'b0, 1'b1, '0);
    idle(2);
    chk("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
